// File: rtl/rdcmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rdcmd_pkg
// Description : Shared types and constants for the read-command scheduler.
//               Holds the FSM state encoding, beat geometry and the fixed AXI
//               AR attribute values.
// Revision    : 1.0 - initial release
// ============================================================================
package rdcmd_pkg;

  // Job-level FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARAM = 3'd1,
    ST_MB    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned BEAT_BYTES  = 128;
  localparam int unsigned BEAT_SHIFT  = 7;    // log2(BEAT_BYTES)
  localparam int unsigned PARAM_BEATS = 6;
  localparam int unsigned MB_BEATS    = 3;
  localparam int unsigned PAGE_BEATS  = 32;   // beats per 4 KB page

  localparam logic [2:0] AXI_SIZE_128B  = 3'b111;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage : rdcmd_pkg
`default_nettype wire

// File: rtl/rdcmd_burst_split.sv
`default_nettype none
// ============================================================================
// Module      : rdcmd_burst_split
// Description : Combinational burst sizer. Returns arlen for the next burst:
//               the remaining beats of the current request, clipped so the
//               burst never crosses a 4 KB boundary. Addresses are
//               beat-aligned, so only the beat index inside the page matters.
// Revision    : 1.0 - initial release
// ============================================================================
module rdcmd_burst_split
  import rdcmd_pkg::*;
(
  input  logic [4:0] page_beat,   // address bits [11:7]
  input  logic [2:0] rem_beats,   // beats still to request, 1..6
  output logic [7:0] arlen
);

  logic [5:0] room_beats;
  logic [5:0] rem_ext;
  logic [5:0] burst_beats;

  // Take the smaller of what is left and what fits before the page end
  always_comb begin
    room_beats  = 6'(PAGE_BEATS) - {1'b0, page_beat};
    rem_ext     = {3'b000, rem_beats};
    burst_beats = (rem_ext < room_beats) ? rem_ext : room_beats;
    arlen       = {2'b00, burst_beats} - 8'd1;
  end

endmodule : rdcmd_burst_split
`default_nettype wire

// File: rtl/rdcmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rdcmd_scheduler
// Description : Issues the AXI read-address stream for one decode job: a
//               6-beat parameter request followed by a 3-beat request per
//               macroblock, split at 4 KB boundaries and throttled by the
//               number of bursts still waiting for their last R beat.
// Config      : RDCMD_ERR_ABORT_EN - when defined, a read error during the
//               request phase stops issuing and drains the job early.
// Revision    : 1.0 - initial release
// ============================================================================
module rdcmd_scheduler
  import rdcmd_pkg::*;
#(
  parameter int ID_WIDTH        = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_pulse,
  input  logic [63:0]         src_addr,
  input  logic [15:0]         mb_num,
  input  logic [1:0]          rd_error,
  output logic [63:0]         m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic [ID_WIDTH-1:0] m_axi_arid,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic                m_axi_rvalid,
  input  logic                m_axi_rready,
  input  logic                m_axi_rlast,
  output logic                busy,
  output logic                done_pulse,
  output logic                job_err
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;       // address of the burst being / to be issued
  logic [7:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d;
  logic [2:0]  rem_q, rem_d;         // beats of the current request not yet accepted
  logic [15:0] mb_left_q, mb_left_d; // macroblock requests not yet started
  logic [3:0]  out_q, out_d;         // bursts accepted but without rlast yet
  logic        job_err_q, job_err_d;

  logic        ar_hs;
  logic        r_last_hs;
  logic        abort_now;
  logic        in_req_phase;
  logic [63:0] addr_n;
  logic [2:0]  rem_n;
  logic [7:0]  split_len;
  logic        unused_rd_err;

  assign ar_hs        = arvalid_q && m_axi_arready;
  assign r_last_hs    = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign in_req_phase = (state_q == ST_PARAM) || (state_q == ST_MB);
  assign unused_rd_err = rd_error[1];

`ifdef RDCMD_ERR_ABORT_EN
  logic abort_q, abort_d;

  // Remember a request-phase error so issuing stays stopped until the drain
  always_comb begin
    abort_d = abort_q;
    if (state_q == ST_IDLE) begin
      abort_d = 1'b0;
    end else if (in_req_phase && rd_error[0]) begin
      abort_d = 1'b1;
    end
  end

  // Abort flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end

  assign abort_now = in_req_phase && (abort_q || rd_error[0]);
`else
  assign abort_now = 1'b0;
`endif

  // Outstanding-burst counter: saturating, simultaneous +1/-1 cancels
  always_comb begin
    out_d = out_q;
    if (ar_hs && !r_last_hs) begin
      if (out_q != 4'hF) out_d = out_q + 4'd1;
    end else if (!ar_hs && r_last_hs) begin
      if (out_q != 4'h0) out_d = out_q - 4'd1;
    end
  end

  // Advance the request pointer on handshakes and walk the job FSM
  always_comb begin
    state_d   = state_q;
    addr_n    = addr_q;
    rem_n     = rem_q;
    mb_left_d = mb_left_q;
    job_err_d = job_err_q;

    if (ar_hs) begin
      addr_n = addr_q + (({56'd0, arlen_q} + 64'd1) << BEAT_SHIFT);
      rem_n  = rem_q - arlen_q[2:0] - 3'd1;
    end

    if (busy && rd_error[0]) job_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d   = ST_PARAM;
          addr_n    = src_addr;
          rem_n     = 3'(PARAM_BEATS);
          mb_left_d = mb_num;
          job_err_d = 1'b0;
        end
      end
      ST_PARAM, ST_MB: begin
        if (abort_now) begin
          // let a burst already on the bus complete its handshake first
          if (!arvalid_q || ar_hs) state_d = ST_DRAIN;
        end else if (rem_n == 3'd0) begin
          if (mb_left_q == 16'd0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d   = ST_MB;
            rem_n     = 3'(MB_BEATS);
            mb_left_d = mb_left_q - 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_q == 4'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  rdcmd_burst_split u_split (
    .page_beat (addr_n[11:7]),
    .rem_beats (rem_n),
    .arlen     (split_len)
  );

  // Present the next burst, back-to-back when the credit allows
  always_comb begin
    arvalid_d = arvalid_q;
    arlen_d   = arlen_q;
    addr_d    = addr_n;
    rem_d     = rem_n;
    if (ar_hs) arvalid_d = 1'b0;
    if (((state_d == ST_PARAM) || (state_d == ST_MB)) && (!arvalid_q || ar_hs) &&
        (rem_n != 3'd0) && !abort_now && (out_d < MAX_OUT)) begin
      arvalid_d = 1'b1;
      arlen_d   = split_len;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 64'd0;
      arlen_q   <= 8'd0;
      arvalid_q <= 1'b0;
      rem_q     <= 3'd0;
      mb_left_q <= 16'd0;
      out_q     <= 4'd0;
      job_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      rem_q     <= rem_d;
      mb_left_q <= mb_left_d;
      out_q     <= out_d;
      job_err_q <= job_err_d;
    end
  end

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arsize  = AXI_SIZE_128B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = '0;
  assign busy          = (state_q != ST_IDLE);
  assign done_pulse    = (state_q == ST_DONE);
  assign job_err       = job_err_q;

endmodule : rdcmd_scheduler
`default_nettype wire
